// File: rtl/alu_sequencer.sv
// Sequences one operation at a time through an external combinational ALU:
// accept in IDLE, sample the ALU in EXEC, hold the response in DONE until taken.
module alu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_src_A,
  output logic [WIDTH-1:0] alu_src_B,
  output logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [15:0]      op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_op;
  logic             r_illegal;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_err;
  logic [15:0]      r_op_count;
  logic             r_req_ready;
  logic             r_rsp_valid;
  logic             w_legal;
  logic             w_div_zero;

  function automatic logic op_is_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011,
      4'b0100, 4'b0101, 4'b1000, 4'b1001,
      4'b1010, 4'b1011, 4'b1110, 4'b1111: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  assign w_legal    = op_is_legal(req_op);
  assign w_div_zero = (r_op == 4'b0011) && (r_b == {WIDTH{1'b0}});

  // Next-state decode for the three-state handshake sequencer
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) w_next = S_EXEC;
        else           w_next = S_IDLE;
      end
      S_EXEC: w_next = S_DONE;
      S_DONE: begin
        if (rsp_ready) w_next = S_IDLE;
        else           w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, operand capture, response capture and completion counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_op        <= 4'd0;
      r_illegal   <= 1'b0;
      r_a         <= {WIDTH{1'b0}};
      r_b         <= {WIDTH{1'b0}};
      r_result    <= {WIDTH{1'b0}};
      r_zero      <= 1'b0;
      r_err       <= 1'b0;
      r_op_count  <= 16'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_req_ready <= (w_next == S_IDLE);
      r_rsp_valid <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            // Illegal codes are squashed to 0000 so the ALU never sees them
            r_op      <= w_legal ? req_op : 4'd0;
            r_illegal <= ~w_legal;
            r_a       <= req_a;
            r_b       <= req_b;
          end
        end
        S_EXEC: begin
          if (r_illegal) begin
            r_result <= {WIDTH{1'b0}};
            r_zero   <= 1'b1;
            r_err    <= 1'b1;
          end else if (w_div_zero) begin
            r_result <= {WIDTH{1'b1}};
            r_zero   <= 1'b0;
            r_err    <= 1'b1;
          end else begin
            r_result <= alu_result;
            r_zero   <= alu_zero;
            r_err    <= 1'b0;
          end
        end
        S_DONE: begin
          if (rsp_ready) r_op_count <= r_op_count + 16'd1;
        end
        default: begin
          r_op_count <= r_op_count;
        end
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign alu_src_A   = r_a;
  assign alu_src_B   = r_b;
  assign alu_control = r_op;
  assign rsp_result  = r_result;
  assign rsp_zero    = r_zero;
  assign rsp_err     = r_err;
  assign op_count    = r_op_count;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed vector table, random ops
// against a reference model, plus backpressure, reset-abort and counter-wrap sequences.
module tb_alu_sequencer;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_op;
  logic [W-1:0]  req_a;
  logic [W-1:0]  req_b;
  logic [W-1:0]  alu_src_A;
  logic [W-1:0]  alu_src_B;
  logic [3:0]    alu_control;
  logic [W-1:0]  alu_result;
  logic          alu_zero;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_result;
  logic          rsp_zero;
  logic          rsp_err;
  logic [15:0]   op_count;

  int            tests = 0;
  int            fails = 0;
  logic [15:0]   exp_count;

  alu_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_src_A(alu_src_A), .alu_src_B(alu_src_B), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Environment ALU: unsigned arithmetic, driven only by the sequencer outputs
  always_comb begin
    alu_result = '0;
    case (alu_control)
      4'h0: alu_result = alu_src_A + alu_src_B;
      4'h1: alu_result = alu_src_A - alu_src_B;
      4'h2: alu_result = alu_src_A * alu_src_B;
      4'h3: alu_result = (alu_src_B == '0) ? 32'h1234_5678 : alu_src_A / alu_src_B;
      4'h4: alu_result = alu_src_A << 1;
      4'h5: alu_result = alu_src_A >> 1;
      4'h8: alu_result = alu_src_A & alu_src_B;
      4'h9: alu_result = alu_src_A | alu_src_B;
      4'hA: alu_result = alu_src_A ^ alu_src_B;
      4'hB: alu_result = ~(alu_src_A | alu_src_B);
      4'hE: alu_result = {31'd0, alu_src_A > alu_src_B};
      4'hF: alu_result = {31'd0, alu_src_A == alu_src_B};
      default: alu_result = 32'hDEAD_BEEF;
    endcase
    alu_zero = (alu_result == '0);
  end

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         zero;
    logic         err;
  } vec_t;

  vec_t vecs[12];

  function automatic logic is_legal(input logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB, 4'hE, 4'hF};
  endfunction

  // Reference: {err, zero, result} straight from the operation rules
  function automatic logic [W+1:0] ref_model(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [W-1:0] r;
    if (!is_legal(op)) return {1'b1, 1'b1, {W{1'b0}}};
    if (op == 4'h3 && b == 0) return {1'b0 | 1'b1, 1'b0, {W{1'b1}}};
    unique case (op)
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h2: r = W'(longint'(a) * longint'(b));
      4'h3: r = a / b;
      4'h4: r = a * 2;
      4'h5: r = a / 2;
      4'h8: r = a & b;
      4'h9: r = a | b;
      4'hA: r = a ^ b;
      4'hB: r = ~a & ~b;
      4'hE: r = (a > b) ? 1 : 0;
      default: r = (a == b) ? 1 : 0;
    endcase
    return {1'b0, r == 0, r};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with rsp_ready held high; stray requests during the op must be ignored
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] res,
                        input logic zero, input logic err);
    chk({tag, " req_ready idle"}, req_ready, 1'b1);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1; rsp_ready = 1'b1;
    tick();
    req_op = 4'h2; req_a = ~a; req_b = ~b;
    chk({tag, " exec rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, " exec req_ready"}, req_ready, 1'b0);
    chk({tag, " alu_control"}, alu_control, is_legal(op) ? op : 4'h0);
    chk({tag, " alu_src_A"}, alu_src_A, a);
    tick();
    req_valid = 1'b0;
    chk({tag, " rsp_valid"}, rsp_valid, 1'b1);
    chk({tag, " rsp_result"}, rsp_result, res);
    chk({tag, " rsp_zero"}, rsp_zero, zero);
    chk({tag, " rsp_err"}, rsp_err, err);
    chk({tag, " alu_src_B held"}, alu_src_B, b);
    tick();
    exp_count = exp_count + 16'd1;
    chk({tag, " after rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, " op_count"}, op_count, exp_count);
  endtask

  initial begin
    logic [W+1:0] r;
    logic [3:0]   op;
    logic [W-1:0] a, b;

    vecs[0]  = '{4'h0, 32'd5,   32'd7,  32'd12,         1'b0, 1'b0};
    vecs[1]  = '{4'h1, 32'd9,   32'd9,  32'd0,          1'b1, 1'b0};
    vecs[2]  = '{4'h3, 32'd100, 32'd0,  32'hFFFF_FFFF,  1'b0, 1'b1};
    vecs[3]  = '{4'h6, 32'd3,   32'd4,  32'd0,          1'b1, 1'b1};
    vecs[4]  = '{4'h2, 32'd6,   32'd7,  32'd42,         1'b0, 1'b0};
    vecs[5]  = '{4'h3, 32'd100, 32'd7,  32'd14,         1'b0, 1'b0};
    vecs[6]  = '{4'h4, 32'h8000_0001, 32'd0, 32'd2,     1'b0, 1'b0};
    vecs[7]  = '{4'h5, 32'd9,   32'd0,  32'd4,          1'b0, 1'b0};
    vecs[8]  = '{4'hB, 32'h0F0F_0000, 32'h0000_F0F0, 32'hF0F0_0F0F, 1'b0, 1'b0};
    vecs[9]  = '{4'hE, 32'd3,   32'd8,  32'd0,          1'b1, 1'b0};
    vecs[10] = '{4'hF, 32'd8,   32'd8,  32'd1,          1'b0, 1'b0};
    vecs[11] = '{4'hD, 32'd1,   32'd2,  32'd0,          1'b1, 1'b1};

    reset = 1'b1; req_valid = 1'b1; req_op = 4'h0; req_a = 32'd1; req_b = 32'd2; rsp_ready = 1'b1;
    tick(); tick();
    chk("reset req_ready", req_ready, 1'b1);
    chk("reset rsp_valid", rsp_valid, 1'b0);
    chk("reset op_count", op_count, 16'd0);
    chk("reset alu_src_A", alu_src_A, 32'd0);
    chk("reset rsp_result", rsp_result, 32'd0);
    reset = 1'b0; req_valid = 1'b0;
    exp_count = 16'd0;
    tick();

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].zero, vecs[i].err);

    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'd0;
      else if ($urandom_range(0, 3) == 0) b = a;
      r = ref_model(op, a, b);
      run_op($sformatf("rnd%0d op%0h", i, op), op, a, b, r[W-1:0], r[W], r[W+1]);
    end

    // Backpressure: response must hold while rsp_ready is low
    req_op = 4'h1; req_a = 32'd9; req_b = 32'd9; req_valid = 1'b1; rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    req_valid = 1'b1; req_op = 4'h0; req_a = 32'd77;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp rsp_valid c%0d", i), rsp_valid, 1'b1);
      chk($sformatf("bp rsp_result c%0d", i), rsp_result, 32'd0);
      chk($sformatf("bp rsp_zero c%0d", i), rsp_zero, 1'b1);
      chk($sformatf("bp req_ready c%0d", i), req_ready, 1'b0);
      chk($sformatf("bp op_count c%0d", i), op_count, exp_count);
      tick();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    exp_count = exp_count + 16'd1;
    chk("bp done rsp_valid", rsp_valid, 1'b0);
    chk("bp done req_ready", req_ready, 1'b1);
    chk("bp done op_count", op_count, exp_count);
    chk("bp stray not accepted", alu_src_A, 32'd9);

    // Reset during EXEC drops the op
    req_op = 4'h0; req_a = 32'd1; req_b = 32'd1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_count = 16'd0;
    chk("rst mid rsp_valid", rsp_valid, 1'b0);
    chk("rst mid req_ready", req_ready, 1'b1);
    chk("rst mid op_count", op_count, 16'd0);
    chk("rst mid alu_control", alu_control, 4'h0);
    chk("rst mid alu_src_B", alu_src_B, 32'd0);
    chk("rst mid rsp_result", rsp_result, 32'd0);
    chk("rst mid rsp_err", rsp_err, 1'b0);
    tick();
    chk("rst mid no late rsp", rsp_valid, 1'b0);

    // Counter wrap
    force dut.r_op_count = 16'hFFFF;
    tick();
    release dut.r_op_count;
    tick();
    chk("wrap preload", op_count, 16'hFFFF);
    exp_count = 16'hFFFF;
    run_op("wrap", 4'h0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);
    chk("wrap to zero", op_count, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
